// File: rtl/operand_stage_pkg.sv
// Shared types for the operand stage: opcode classes, operand-select enums,
// the select functions that map an opcode class onto operand sources, and FSM states.
package operand_stage_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OPC_NOP    = 4'd0,
    OPC_LUI    = 4'd1,
    OPC_AUIPC  = 4'd2,
    OPC_JAL    = 4'd3,
    OPC_JALR   = 4'd4,
    OPC_OP     = 4'd5,
    OPC_OP_IMM = 4'd6,
    OPC_LOAD   = 4'd7,
    OPC_STORE  = 4'd8,
    OPC_BRANCH = 4'd9
  } opc_e;

  localparam opc_e NOP_OP = OPC_NOP;

  typedef enum logic [1:0] {ASEL_ZERO, ASEL_PC, ASEL_RS1} asel_e;
  typedef enum logic [1:0] {BSEL_IMM, BSEL_ZERO, BSEL_RS2} bsel_e;

  typedef enum logic {ST_EMPTY, ST_FULL} stage_state_e;

  function automatic asel_e op_a_sel(input opc_e op);
    case (op)
      OPC_LUI:            return ASEL_ZERO;
      OPC_AUIPC, OPC_JAL: return ASEL_PC;
      default:            return ASEL_RS1;
    endcase
  endfunction

  function automatic bsel_e op_b_sel(input opc_e op);
    case (op)
      OPC_LUI, OPC_AUIPC, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_JALR: return BSEL_IMM;
      OPC_JAL:                                                       return BSEL_ZERO;
      default:                                                       return BSEL_RS2;
    endcase
  endfunction

endpackage

// File: rtl/operand_stage_if.sv
// Decode-side, forwarding and execute-side signals of the operand stage.
// Handshake: a transfer happens on a clock edge where valid and ready are both high; valid never waits on ready.
interface operand_stage_if #(
   parameter int XLEN = 64,
   parameter int NFWD = 2,
   parameter int RIDX = 5
);
   import operand_stage_pkg::*;

   logic                       flush;
   logic                       in_valid;
   logic                       in_ready;
   opc_e                       in_op;
   logic [XLEN-1:0]            in_pc;
   logic [XLEN-1:0]            in_imm;
   logic [RIDX-1:0]            in_rs1;
   logic [RIDX-1:0]            in_rs2;
   logic [XLEN-1:0]            in_rs1_data;
   logic [XLEN-1:0]            in_rs2_data;
   logic [RIDX-1:0]            in_rd;
   logic [NFWD-1:0]            fwd_valid;
   logic [NFWD-1:0][RIDX-1:0]  fwd_rd;
   logic [NFWD-1:0][XLEN-1:0]  fwd_data;
   logic [NFWD-1:0]            fwd_pending;
   logic                       out_valid;
   logic                       out_ready;
   opc_e                       out_op;
   logic [XLEN-1:0]            out_pc;
   logic [RIDX-1:0]            out_rd;
   logic [XLEN-1:0]            out_a;
   logic [XLEN-1:0]            out_b;

   modport master (
      output flush, in_valid, in_op, in_pc, in_imm, in_rs1, in_rs2, in_rs1_data, in_rs2_data,
             in_rd, fwd_valid, fwd_rd, fwd_data, fwd_pending, out_ready,
      input  in_ready, out_valid, out_op, out_pc, out_rd, out_a, out_b
   );

   modport slave (
      input  flush, in_valid, in_op, in_pc, in_imm, in_rs1, in_rs2, in_rs1_data, in_rs2_data,
             in_rd, fwd_valid, fwd_rd, fwd_data, fwd_pending, out_ready,
      output in_ready, out_valid, out_op, out_pc, out_rd, out_a, out_b
   );

endinterface

// File: rtl/operand_stage_fwd_resolve.sv
// Resolves one source register against the forwarding channels (lowest index wins).
// Build option OPERAND_FWD_EN: bypass channel data; otherwise any match interlocks.
module operand_stage_fwd_resolve #(
   parameter int XLEN = 64,
   parameter int NFWD = 2,
   parameter int RIDX = 5
) (
   input  logic                      needed,
   input  logic [RIDX-1:0]           rs,
   input  logic [XLEN-1:0]           rf_data,
   input  logic [NFWD-1:0]           fwd_valid,
   input  logic [NFWD-1:0][RIDX-1:0] fwd_rd,
   input  logic [NFWD-1:0][XLEN-1:0] fwd_data,
   input  logic [NFWD-1:0]           fwd_pending,
   output logic [XLEN-1:0]           value,
   output logic                      hazard
);

   logic found;
   logic raw_hazard;

`ifndef OPERAND_FWD_EN
   logic unused_fwd;
   assign unused_fwd = ^{fwd_data, fwd_pending};
`endif

   always_comb begin
      value      = (rs == '0) ? '0 : rf_data;
      raw_hazard = 1'b0;
      found      = 1'b0;
      for (int i = 0; i < NFWD; i++) begin
         if (!found && fwd_valid[i] && (fwd_rd[i] == rs) && (rs != '0)) begin
            found = 1'b1;
`ifdef OPERAND_FWD_EN
            value      = fwd_data[i];
            raw_hazard = fwd_pending[i];
`else
            raw_hazard = 1'b1;
`endif
         end
      end
      // An operand that does not read this source must never stall the stage.
      hazard = needed & raw_hazard;
   end

endmodule

// File: rtl/operand_stage.sv
// Operand select, RAW resolution and one-entry valid/ready issue register.
// Build option OPERAND_FWD_EN: bypass from forwarding channels instead of interlocking.
module operand_stage
   import operand_stage_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int NFWD = 2,
   parameter int RIDX = 5
) (
   input  logic           clk,
   input  logic           reset_n,
   operand_stage_if.slave bus,
   output logic [31:0]    stall_cycles,
   output stage_state_e   state_dbg
);

   stage_state_e    state_q, state_d;
   asel_e           a_sel;
   bsel_e           b_sel;
   logic [XLEN-1:0] rs1_val, rs2_val, a_val, b_val;
   logic            rs1_haz, rs2_haz, hazard, accept, stall;

   assign a_sel = op_a_sel(bus.in_op);
   assign b_sel = op_b_sel(bus.in_op);

   operand_stage_fwd_resolve #(.XLEN(XLEN), .NFWD(NFWD), .RIDX(RIDX)) u_rs1 (
      .needed(a_sel == ASEL_RS1), .rs(bus.in_rs1), .rf_data(bus.in_rs1_data),
      .fwd_valid(bus.fwd_valid), .fwd_rd(bus.fwd_rd), .fwd_data(bus.fwd_data),
      .fwd_pending(bus.fwd_pending), .value(rs1_val), .hazard(rs1_haz)
   );

   operand_stage_fwd_resolve #(.XLEN(XLEN), .NFWD(NFWD), .RIDX(RIDX)) u_rs2 (
      .needed(b_sel == BSEL_RS2), .rs(bus.in_rs2), .rf_data(bus.in_rs2_data),
      .fwd_valid(bus.fwd_valid), .fwd_rd(bus.fwd_rd), .fwd_data(bus.fwd_data),
      .fwd_pending(bus.fwd_pending), .value(rs2_val), .hazard(rs2_haz)
   );

   always_comb begin
      a_val = rs1_val;
      case (a_sel)
         ASEL_ZERO: a_val = '0;
         ASEL_PC:   a_val = bus.in_pc;
         default:   a_val = rs1_val;
      endcase
      b_val = rs2_val;
      case (b_sel)
         BSEL_IMM:  b_val = bus.in_imm;
         BSEL_ZERO: b_val = '0;
         default:   b_val = rs2_val;
      endcase
   end

   assign hazard       = rs1_haz | rs2_haz;
   assign bus.in_ready = ((state_q == ST_EMPTY) | bus.out_ready) & ~hazard & ~bus.flush;
   assign accept       = bus.in_valid & bus.in_ready;
   assign stall        = bus.in_valid & hazard & ~bus.flush;
   assign bus.out_valid = (state_q == ST_FULL);
   assign state_dbg    = state_q;

   // Flush wins over everything; accept already excludes flush.
   always_comb begin
      state_d = state_q;
      if (bus.flush)                           state_d = ST_EMPTY;
      else if (accept)                         state_d = ST_FULL;
      else if (state_q == ST_FULL && bus.out_ready) state_d = ST_EMPTY;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_EMPTY;
      else          state_q <= state_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.out_op <= NOP_OP;
         bus.out_pc <= '0;
         bus.out_rd <= '0;
         bus.out_a  <= '0;
         bus.out_b  <= '0;
      end else if (accept) begin
         bus.out_op <= bus.in_op;
         bus.out_pc <= bus.in_pc;
         bus.out_rd <= bus.in_rd;
         bus.out_a  <= a_val;
         bus.out_b  <= b_val;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                         stall_cycles <= '0;
      else if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
   end

endmodule
